// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle MULTU/DIVU controller driving a shared external ALU, owns HI/LO
module muldiv_sequencer #(
  parameter int WIDTH = 32,
  parameter logic [2:0] OP_ADD = 3'b010,
  parameter logic [2:0] OP_SUB = 3'b110,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  output logic             alu_c_in,
  input  logic [WIDTH-1:0] alu_r,
  input  logic             alu_c_out
);
  typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;
  state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [WIDTH-1:0] opb, opb_n, hi_n, lo_n, s;
  logic dbz_n, dbz_start, take;
  assign s = {hi[WIDTH-2:0], lo[WIDTH-1]};
  assign take = hi[WIDTH-1] | alu_c_out;
  assign dbz_start = is_div && op_b == '0;
  assign busy = state != IDLE;
  assign done = state == FIN;
  // ALU drive depends only on registered state, so start never reaches alu_*
  always_comb begin
    alu_a = '0;
    alu_b = '0;
    alu_op = OP_ADD;
    alu_c_in = 1'b0;
    if (state == MUL) begin
      alu_a = hi;
      alu_b = opb;
    end else if (state == DIV) begin
      alu_a = s;
      alu_b = opb;
      alu_op = OP_SUB;
      alu_c_in = 1'b1;
    end
  end
  // next-state: launch, shift-add multiply step, restoring divide step
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    opb_n = opb;
    hi_n = hi;
    lo_n = lo;
    dbz_n = div_by_zero;
    case (state)
      IDLE: if (start) begin
        opb_n = op_b;
        cnt_n = '0;
        dbz_n = dbz_start;
        hi_n = dbz_start ? op_a : '0;
        lo_n = dbz_start ? '1 : op_a;
        state_n = dbz_start ? FIN : is_div ? DIV : MUL;
      end
      MUL: begin
        {hi_n, lo_n} = lo[0] ? {alu_c_out, alu_r, lo[WIDTH-1:1]} : {1'b0, hi, lo[WIDTH-1:1]};
        cnt_n = cnt + 1'b1;
        state_n = &cnt ? FIN : MUL;
      end
      DIV: begin
        hi_n = take ? alu_r : s;
        lo_n = {lo[WIDTH-2:0], take};
        cnt_n = cnt + 1'b1;
        state_n = &cnt ? FIN : DIV;
      end
      default: state_n = IDLE;
    endcase
  end
  // state and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      opb <= '0;
      hi <= '0;
      lo <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      opb <= opb_n;
      hi <= hi_n;
      lo <= lo_n;
      div_by_zero <= dbz_n;
    end
  end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed MULTU/DIVU vectors against a behavioural ALU
module tb_muldiv_sequencer;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  logic clk, rst, start, is_div, busy, done, div_by_zero, alu_c_in, alu_c_out;
  logic [31:0] op_a, op_b, hi, lo, alu_a, alu_b, alu_r;
  logic [2:0] alu_op;
  int n_checks = 0, n_fail = 0;
  int lat, busy_n;
  logic saw_sub, saw_cin, got_done, late_done;

  muldiv_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .is_div(is_div), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_c_in(alu_c_in),
    .alu_r(alu_r), .alu_c_out(alu_c_out)
  );

  // behavioural ALU: subtract is a + ~b + c_in, carry-out 1 means no borrow
  always_comb {alu_c_out, alu_r} = {1'b0, alu_a} + {1'b0, (alu_op == OP_SUB) ? ~alu_b : alu_b} + {32'd0, alu_c_in};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run(input logic d, input logic [31:0] a, input logic [31:0] b,
                     input int restart_at, input int rst_at);
    @(negedge clk);
    start = 1'b1; is_div = d; op_a = a; op_b = b;
    @(negedge clk);
    start = 1'b0; is_div = $urandom; op_a = $urandom; op_b = $urandom;
    lat = 1; busy_n = 0; saw_sub = 1'b0; saw_cin = 1'b0; got_done = 1'b0;
    while (lat < 60) begin
      if (busy) busy_n++;
      if (alu_op != OP_ADD) saw_sub = 1'b1;
      if (alu_c_in) saw_cin = 1'b1;
      if (done) begin
        got_done = 1'b1;
        break;
      end
      if (lat == rst_at) begin
        rst = 1'b1;
        #1;
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        check("rst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        break;
      end
      if (lat == restart_at) begin
        start = 1'b1; is_div = 1'b0; op_a = 9; op_b = 9;
      end else start = 1'b0;
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
  endtask

  task automatic after_done;
    @(negedge clk);
    check("done_pulse", done, 0);
    check("idle_busy", busy, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; is_div = 1'b0; op_a = '0; op_b = '0;
    repeat (2) @(negedge clk);
    check("reset_hi", hi, 0);
    check("reset_lo", lo, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_dbz", div_by_zero, 0);
    check("reset_aluop", alu_op, OP_ADD);
    rst = 1'b0;

    run(1'b0, 32'd7, 32'd6, -1, -1);
    check("mul1_done", got_done, 1);
    check("mul1_lat", lat, 33);
    check("mul1_busy", busy_n, 33);
    check("mul1_prod", {hi, lo}, 64'd42);
    check("mul1_alu", {saw_sub, saw_cin}, 0);
    after_done();
    repeat (3) @(negedge clk);
    check("mul1_hold", {hi, lo}, 64'd42);

    run(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1);
    check("mul2_done", got_done, 1);
    check("mul2_prod", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    after_done();

    run(1'b1, 32'd100, 32'd7, -1, -1);
    check("div1_done", got_done, 1);
    check("div1_lat", lat, 33);
    check("div1_alu", {saw_sub, saw_cin}, 2'b11);
    check("div1_q", lo, 14);
    check("div1_r", hi, 2);
    after_done();

    run(1'b1, 32'hFFFF_FFFF, 32'h8000_0001, -1, -1);
    check("div2_q", lo, 1);
    check("div2_r", hi, 32'h7FFF_FFFE);

    run(1'b1, 32'h1234, 32'd0, -1, -1);
    check("dz_done", got_done, 1);
    check("dz_lat", lat, 1);
    check("dz_flag", div_by_zero, 1);
    check("dz_hi", hi, 32'h1234);
    check("dz_lo", lo, 32'hFFFF_FFFF);
    after_done();
    repeat (3) @(negedge clk);
    check("dz_hold", div_by_zero, 1);
    run(1'b0, 32'd2, 32'd3, -1, -1);
    check("dz_clear", div_by_zero, 0);
    check("mul3_lo", lo, 6);

    run(1'b0, 32'd3, 32'd5, 10, -1);
    check("ign_lat", lat, 33);
    check("ign_prod", {hi, lo}, 64'd15);
    check("ign_alu", {saw_sub, saw_cin}, 0);
    after_done();
    repeat (3) @(negedge clk);
    check("ign_noqueue", busy, 0);

    run(1'b1, 32'd1000, 32'd3, -1, 12);
    check("abort_nodone", got_done, 0);
    late_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      late_done |= done | busy;
    end
    check("abort_quiet", late_done, 0);
    run(1'b1, 32'd1000, 32'd3, -1, -1);
    check("div3_done", got_done, 1);
    check("div3_q", lo, 333);
    check("div3_r", hi, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
